hub75_bcm_driver: RTL and testbench
===================================

HUB75_BCM_DRIVER -- requirements
Module: hub75_bcm_driver

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
REQ-002 COLS, 32, columns per shift chain; power of two, >=2; CB = log2(COLS).
REQ-003 ROW_BITS, 3, scan-row address width; the panel has 2^ROW_BITS scan rows per half.
REQ-004 DEPTH, 4, bit planes per colour channel; 1..8.
REQ-005 BASE_DELAY, 8, led_clk cycles of output enable for bit plane 0; >=1.
REQ-006 Ports SHALL be, one per line: name, direction, width, meaning.
REQ-007 led_clk, in, 1, clock; all state on rising edge.
REQ-008 rst_i, in, 1, reset; asynchronous, active-high.
REQ-009 enable, in, 1, permits start of a new plane scan; sampled only in IDLE.
REQ-010 pix_addr, out, ROW_BITS+CB, pixel read address {rowpos, colpos}.
REQ-011 pix_top, in, 3*DEPTH, upper-half pixel {R,G,B}, each DEPTH bits, MSB-first; valid 1 cycle after pix_addr.
REQ-012 pix_bot, in, 3*DEPTH, lower-half pixel, same format and latency.
REQ-013 demux, out, ROW_BITS, scan-row select; equals rowpos.
REQ-014 matrix0 / matrix1, out, 3, registered {R,G,B} serial data for the upper / lower half.
REQ-015 matrix_clk, out, 1, shift clock to the panel.
REQ-016 matrix_stb, out, 1, latch strobe.
REQ-017 oe_n, out, 1, active-low output enable.
REQ-018 frame_done, out, 1, one-cycle pulse at the end of the last plane of the last row.

Function
REQ-019 States SHALL be IDLE, ADDR, SHIFT, CLOCK, LATCH and DISPLAY; matrix_clk, matrix_stb and oe_n SHALL be decoded from the registered state only.
REQ-020 IDLE: go to ADDR if enable=1, else hold; on entry, colpos = 0.
REQ-021 ADDR: drive pix_addr = {rowpos, colpos}; go to SHIFT.
REQ-022 SHIFT: register the following, then go to CLOCK:
- matrix0 = {pix_top[2*DEPTH+plane], pix_top[DEPTH+plane], pix_top[plane]}
- matrix1 = the same bits of pix_bot
REQ-023 CLOCK: matrix_clk=1 for exactly this one cycle; colpos increments modulo COLS.
- If colpos was COLS-1, go to LATCH; otherwise go to ADDR.
REQ-024 Column 0 SHALL be shifted first; exactly COLS matrix_clk pulses SHALL occur per plane.
REQ-025 LATCH: matrix_stb=1 for exactly one cycle; load delay = BASE_DELAY << plane; go to DISPLAY.
REQ-026 DISPLAY: oe_n=0; decrement delay each cycle; when delay reaches 1, go to IDLE. oe_n is therefore low for exactly BASE_DELAY<<plane cycles.
REQ-027 On leaving DISPLAY:
- If plane < DEPTH-1, increment plane and keep rowpos.
- Otherwise set plane = 0 and increment rowpos modulo 2^ROW_BITS.
REQ-028 If rowpos wraps from 2^ROW_BITS-1 to 0, frame_done SHALL pulse high for one cycle, concurrent with the first IDLE cycle.
REQ-029 oe_n SHALL be 1 in every state except DISPLAY; demux SHALL change only on the DISPLAY-to-IDLE transition, while oe_n=1.
REQ-030 The delay counter SHALL be wide enough for BASE_DELAY<<(DEPTH-1) without overflow.
REQ-031 Deasserting enable mid-plane SHALL NOT abort the plane; the block completes through DISPLAY and then holds in IDLE with oe_n=1.
REQ-032 matrix0 and matrix1 SHALL hold their value outside SHIFT.
REQ-033 Cycles per plane p SHALL be 1 + 3*COLS + 1 + (BASE_DELAY<<p), with enable held at 1.

Reset
REQ-034 While rst_i=1, the block SHALL hold the following, independent of led_clk:
- state=IDLE; colpos, rowpos and plane = 0; delay = 0
- matrix0, matrix1 = 0; pix_addr = 0; demux = 0
- matrix_clk, matrix_stb, frame_done = 0; oe_n = 1
REQ-035 Assertion of reset at any state, including mid-DISPLAY, SHALL force oe_n=1 immediately and restart at row 0, plane 0, column 0 after release.

Verification (COLS=4, ROW_BITS=1, DEPTH=2, BASE_DELAY=2, enable=1 unless stated)
REQ-036 Timing: free-run for one frame -> 68 cycles per frame; planes take 16 and 18 cycles; oe_n-low runs of 2 and 4 cycles alternate; frame_done pulses once per 68 cycles.
REQ-037 Data path: a memory model returns pix_top=6'b10_01_11 and pix_bot=0 for every address -> plane 0: matrix0=3'b011; plane 1: matrix0=3'b101; matrix1=3'b000; each sampled on matrix_clk high.
REQ-038 Addressing: pix_addr sequence per plane is {r,0},{r,1},{r,2},{r,3}, and demux=r throughout; 4 matrix_clk pulses are followed by exactly 1 matrix_stb.
REQ-039 Enable: drop enable during column 2 of plane 0 -> the plane completes with a 2-cycle oe_n pulse; the block then stays in IDLE with oe_n=1 and no matrix_clk until enable returns.
REQ-040 Reset: assert rst_i mid-DISPLAY of row 1, plane 1 -> oe_n=1 and demux=0 in the same cycle; after release, the first pix_addr is 0 and the first oe_n-low run is 2 cycles.

Source files
------------

// File: rtl/hub75_bcm_driver.sv
// HUB75 LED panel scan driver with binary-coded modulation.
// Each pass shifts one bit plane of one scan row, latches it, then lights it for BASE_DELAY<<plane cycles.
module hub75_bcm_driver #(
  parameter int COLS       = 32,
  parameter int ROW_BITS   = 3,
  parameter int DEPTH      = 4,
  parameter int BASE_DELAY = 8
) (
  input  logic                               led_clk,
  input  logic                               rst_i,
  input  logic                               enable,
  output logic [ROW_BITS+$clog2(COLS)-1:0]   pix_addr,
  input  logic [3*DEPTH-1:0]                 pix_top,
  input  logic [3*DEPTH-1:0]                 pix_bot,
  output logic [ROW_BITS-1:0]                demux,
  output logic [2:0]                         matrix0,
  output logic [2:0]                         matrix1,
  output logic                               matrix_clk,
  output logic                               matrix_stb,
  output logic                               oe_n,
  output logic                               frame_done
);

  localparam int CB        = $clog2(COLS);
  localparam int PB        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MAX_DELAY = BASE_DELAY << (DEPTH - 1);
  localparam int DW        = $clog2(MAX_DELAY + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_SHIFT,
    S_CLOCK,
    S_LATCH,
    S_DISPLAY
  } state_t;

  state_t                state_q, state_d;
  logic [CB-1:0]         colpos_q, colpos_d;
  logic [ROW_BITS-1:0]   rowpos_q, rowpos_d;
  logic [PB-1:0]         plane_q, plane_d;
  logic [DW-1:0]         delay_q, delay_d;
  logic [2:0]            matrix0_q, matrix0_d;
  logic [2:0]            matrix1_q, matrix1_d;
  logic                  frame_done_q, frame_done_d;

  // Per-channel views of the pixel words so the current plane can index each one.
  logic [DEPTH-1:0] top_r, top_g, top_b;
  logic [DEPTH-1:0] bot_r, bot_g, bot_b;

  assign top_r = pix_top[3*DEPTH-1:2*DEPTH];
  assign top_g = pix_top[2*DEPTH-1:DEPTH];
  assign top_b = pix_top[DEPTH-1:0];
  assign bot_r = pix_bot[3*DEPTH-1:2*DEPTH];
  assign bot_g = pix_bot[2*DEPTH-1:DEPTH];
  assign bot_b = pix_bot[DEPTH-1:0];

  always_comb begin
    state_d      = state_q;
    colpos_d     = colpos_q;
    rowpos_d     = rowpos_q;
    plane_d      = plane_q;
    delay_d      = delay_q;
    matrix0_d    = matrix0_q;
    matrix1_d    = matrix1_q;
    frame_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        matrix0_d = {top_r[plane_q], top_g[plane_q], top_b[plane_q]};
        matrix1_d = {bot_r[plane_q], bot_g[plane_q], bot_b[plane_q]};
        state_d   = S_CLOCK;
      end
      S_CLOCK: begin
        colpos_d = colpos_q + 1'b1;
        if (colpos_q == CB'(COLS - 1)) begin
          state_d = S_LATCH;
        end else begin
          state_d = S_ADDR;
        end
      end
      S_LATCH: begin
        delay_d = DW'(BASE_DELAY) << plane_q;
        state_d = S_DISPLAY;
      end
      S_DISPLAY: begin
        if (delay_q <= DW'(1)) begin
          state_d  = S_IDLE;
          delay_d  = '0;
          colpos_d = '0;
          if (plane_q == PB'(DEPTH - 1)) begin
            plane_d  = '0;
            rowpos_d = rowpos_q + 1'b1;
            // Last plane of the last row: the next IDLE cycle opens a new frame.
            frame_done_d = &rowpos_q;
          end else begin
            plane_d = plane_q + 1'b1;
          end
        end else begin
          delay_d = delay_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge led_clk or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      colpos_q     <= '0;
      rowpos_q     <= '0;
      plane_q      <= '0;
      delay_q      <= '0;
      matrix0_q    <= '0;
      matrix1_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      colpos_q     <= colpos_d;
      rowpos_q     <= rowpos_d;
      plane_q      <= plane_d;
      delay_q      <= delay_d;
      matrix0_q    <= matrix0_d;
      matrix1_q    <= matrix1_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Panel strobes come straight from the registered state so they are glitch-free.
  assign pix_addr   = {rowpos_q, colpos_q};
  assign demux      = rowpos_q;
  assign matrix0    = matrix0_q;
  assign matrix1    = matrix1_q;
  assign matrix_clk = (state_q == S_CLOCK);
  assign matrix_stb = (state_q == S_LATCH);
  assign oe_n       = (state_q != S_DISPLAY);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Bench for hub75_bcm_driver: small panel, random pixel memory, schedule-level reference model.
module tb_hub75_bcm_driver;

  localparam int COLS       = 4;
  localparam int ROW_BITS   = 1;
  localparam int DEPTH      = 2;
  localparam int BASE_DELAY = 2;
  localparam int CB         = 2;
  localparam int AW         = ROW_BITS + CB;
  localparam int PW         = 3 * DEPTH;
  localparam int NADDR      = 1 << AW;
  localparam int ROWS       = 1 << ROW_BITS;
  localparam int CW         = ROW_BITS + 4;
  localparam int NMAX       = 200;

  logic                led_clk = 1'b0;
  logic                rst_i   = 1'b1;
  logic                enable  = 1'b0;
  logic [AW-1:0]       pix_addr;
  logic [PW-1:0]       pix_top;
  logic [PW-1:0]       pix_bot;
  logic [ROW_BITS-1:0] demux;
  logic [2:0]          matrix0;
  logic [2:0]          matrix1;
  logic                matrix_clk;
  logic                matrix_stb;
  logic                oe_n;
  logic                frame_done;

  int errors = 0;
  int checks = 0;

  logic [PW-1:0] mem_top [NADDR];
  logic [PW-1:0] mem_bot [NADDR];

  // Trace: ctrl = {matrix_clk, matrix_stb, oe_n, frame_done, demux}
  logic [CW-1:0] tr_ctrl [NMAX];
  logic [5:0]    tr_data [NMAX];
  logic [AW-1:0] tr_addr [NMAX];

  logic [CW-1:0] ex_ctrl   [NMAX];
  logic [5:0]    ex_data   [NMAX];
  logic [5:0]    ex_pulse  [NMAX];
  logic [AW-1:0] ex_addr   [NMAX];
  logic          ex_addr_v [NMAX];

  hub75_bcm_driver #(
    .COLS(COLS), .ROW_BITS(ROW_BITS), .DEPTH(DEPTH), .BASE_DELAY(BASE_DELAY)
  ) dut (
    .led_clk(led_clk), .rst_i(rst_i), .enable(enable), .pix_addr(pix_addr),
    .pix_top(pix_top), .pix_bot(pix_bot), .demux(demux), .matrix0(matrix0),
    .matrix1(matrix1), .matrix_clk(matrix_clk), .matrix_stb(matrix_stb),
    .oe_n(oe_n), .frame_done(frame_done)
  );

  always #5 led_clk = ~led_clk;

  // Pixel memory with one-cycle registered read.
  always @(posedge led_clk) begin
    pix_top <= mem_top[pix_addr];
    pix_bot <= mem_bot[pix_addr];
  end

  task automatic record(input int t);
    tr_ctrl[t] = {matrix_clk, matrix_stb, oe_n, frame_done, demux};
    tr_data[t] = {matrix0, matrix1};
    tr_addr[t] = pix_addr;
  endtask

  // Cycle 0 is the IDLE cycle right after reset release.
  task automatic release_and_trace(input int n);
    rst_i  = 1'b1;
    enable = 1'b1;
    repeat (2) @(posedge led_clk);
    @(negedge led_clk);
    rst_i = 1'b0;
    record(0);
    for (int t = 1; t < n; t++) begin
      @(negedge led_clk);
      record(t);
    end
  endtask

  task automatic randomize_mem();
    for (int a = 0; a < NADDR; a++) begin
      mem_top[a] = PW'($urandom);
      mem_bot[a] = PW'($urandom);
    end
  endtask

  // Schedule of planes: IDLE, COLS x (addr, shift, clock), latch, BASE_DELAY<<p lit cycles.
  task automatic build_model(input int n);
    int t, r, p, d, len, a, idx;
    logic [PW-1:0] top, bot;
    logic [5:0] hold;
    for (int i = 0; i < NMAX; i++) begin
      ex_ctrl[i]   = {4'b0010, ROW_BITS'(0)};
      ex_data[i]   = '0;
      ex_pulse[i]  = '0;
      ex_addr[i]   = '0;
      ex_addr_v[i] = 1'b0;
    end
    t = 0; r = 0; p = 0;
    while (t < n) begin
      d   = BASE_DELAY << p;
      len = 2 + 3 * COLS + d;
      for (int k = 0; k < len; k++)
        if (t + k < NMAX) ex_ctrl[t+k][ROW_BITS-1:0] = ROW_BITS'(r);
      if (t > 0 && r == 0 && p == 0) ex_ctrl[t][ROW_BITS] = 1'b1;
      for (int c = 0; c < COLS; c++) begin
        a   = r * COLS + c;
        top = mem_top[a];
        bot = mem_bot[a];
        idx = t + 1 + 3 * c;
        if (idx < NMAX) begin
          ex_addr[idx]   = AW'(a);
          ex_addr_v[idx] = 1'b1;
        end
        idx = t + 3 + 3 * c;
        if (idx < NMAX) begin
          ex_ctrl[idx][ROW_BITS+3] = 1'b1;
          ex_pulse[idx] = {top[2*DEPTH+p], top[DEPTH+p], top[p],
                           bot[2*DEPTH+p], bot[DEPTH+p], bot[p]};
        end
      end
      idx = t + 1 + 3 * COLS;
      if (idx < NMAX) ex_ctrl[idx][ROW_BITS+2] = 1'b1;
      for (int k = 0; k < d; k++) begin
        idx = t + 2 + 3 * COLS + k;
        if (idx < NMAX) ex_ctrl[idx][ROW_BITS+1] = 1'b0;
      end
      t += len;
      if (p == DEPTH - 1) begin
        p = 0;
        r = (r + 1) % ROWS;
      end else begin
        p++;
      end
    end
    hold = '0;
    for (int i = 0; i < NMAX; i++) begin
      if (ex_ctrl[i][ROW_BITS+3]) hold = ex_pulse[i];
      ex_data[i] = hold;
    end
  endtask

  task automatic test_reset();
    rst_i  = 1'b1;
    enable = 1'b1;
    repeat (3) @(posedge led_clk);
    @(negedge led_clk);
    checks++;
    if ({matrix_clk, matrix_stb, frame_done, oe_n} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_strobes: got clk/stb/fd/oe_n=%b want 0001",
               {matrix_clk, matrix_stb, frame_done, oe_n});
    end
    checks++;
    if (pix_addr !== '0) begin
      errors++;
      $display("FAIL reset_addr: got %0d want 0", pix_addr);
    end
    checks++;
    if (demux !== '0) begin
      errors++;
      $display("FAIL reset_demux: got %0d want 0", demux);
    end
    checks++;
    if ({matrix0, matrix1} !== 6'b0) begin
      errors++;
      $display("FAIL reset_data: got m0=%b m1=%b want 000 000", matrix0, matrix1);
    end
    $display("test_reset done");
  endtask

  task automatic test_frame_timing();
    int nf, bad, first, run, nruns, badrun, nfd, fd0, fd1, ccount, badstb;
    nf = 150;
    randomize_mem();
    release_and_trace(nf);
    build_model(nf);

    bad = 0; first = -1;
    for (int t = 0; t < nf; t++)
      if (tr_ctrl[t] !== ex_ctrl[t]) begin bad++; if (first < 0) first = t; end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL frame_ctrl: %0d bad cycles, first cycle %0d got %b want %b",
               bad, first, tr_ctrl[first], ex_ctrl[first]);
    end

    bad = 0; first = -1;
    for (int t = 0; t < nf; t++)
      if (tr_data[t] !== ex_data[t]) begin bad++; if (first < 0) first = t; end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL frame_data: %0d bad cycles, first cycle %0d got %b want %b",
               bad, first, tr_data[first], ex_data[first]);
    end

    bad = 0; first = -1;
    for (int t = 0; t < nf; t++)
      if (ex_addr_v[t] && tr_addr[t] !== ex_addr[t]) begin bad++; if (first < 0) first = t; end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL frame_addr: %0d bad, first cycle %0d got %0d want %0d",
               bad, first, tr_addr[first], ex_addr[first]);
    end

    run = 0; nruns = 0; badrun = 0;
    for (int t = 0; t < nf; t++) begin
      if (tr_ctrl[t][ROW_BITS+1] === 1'b0) begin
        run++;
      end else if (run > 0) begin
        if (run != (BASE_DELAY << (nruns % DEPTH))) badrun++;
        nruns++;
        run = 0;
      end
    end
    checks++;
    if (nruns != 8 || badrun != 0) begin
      errors++;
      $display("FAIL oe_runs: got %0d runs with %0d wrong lengths, want 8 runs alternating 2/4",
               nruns, badrun);
    end

    nfd = 0; fd0 = -1; fd1 = -1;
    for (int t = 0; t < nf; t++)
      if (tr_ctrl[t][ROW_BITS] === 1'b1) begin
        if (nfd == 0) fd0 = t; else if (nfd == 1) fd1 = t;
        nfd++;
      end
    checks++;
    if (nfd != 2 || fd0 != 68 || fd1 != 136) begin
      errors++;
      $display("FAIL frame_done_period: got %0d pulses at %0d,%0d want 2 at 68,136",
               nfd, fd0, fd1);
    end

    ccount = 0; badstb = 0;
    for (int t = 0; t < nf; t++) begin
      if (tr_ctrl[t][ROW_BITS+3] === 1'b1) ccount++;
      if (tr_ctrl[t][ROW_BITS+2] === 1'b1) begin
        if (ccount != COLS) badstb++;
        ccount = 0;
      end
    end
    checks++;
    if (badstb != 0) begin
      errors++;
      $display("FAIL clk_per_stb: got %0d latches not preceded by %0d clocks, want 0",
               badstb, COLS);
    end
    $display("test_frame_timing done");
  endtask

  task automatic test_datapath();
    int k, bad;
    logic [5:0] want;
    for (int a = 0; a < NADDR; a++) begin
      mem_top[a] = 6'b10_01_11;
      mem_bot[a] = 6'b00_00_00;
    end
    release_and_trace(68);
    k = 0; bad = 0;
    for (int t = 0; t < 68; t++)
      if (tr_ctrl[t][ROW_BITS+3] === 1'b1) begin
        want = (((k / COLS) % DEPTH) == 0) ? 6'b011_000 : 6'b101_000;
        if (tr_data[t] !== want) begin
          bad++;
          $display("FAIL datapath_pulse: pulse %0d got %b want %b", k, tr_data[t], want);
        end
        k++;
      end
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (k != 16) begin
      errors++;
      $display("FAIL datapath_count: got %0d clock pulses want 16", k);
    end
    $display("test_datapath done");
  endtask

  task automatic test_enable();
    int nclk, nstb, noe, viol;
    logic [PW-1:0] top;
    randomize_mem();
    rst_i  = 1'b1;
    enable = 1'b1;
    repeat (2) @(posedge led_clk);
    @(negedge led_clk);
    rst_i = 1'b0;
    record(0);
    for (int t = 1; t < 50; t++) begin
      @(negedge led_clk);
      record(t);
      if (t == 8)  enable = 1'b0;
      if (t == 40) enable = 1'b1;
    end
    nclk = 0; nstb = 0; noe = 0; viol = 0;
    for (int t = 0; t <= 40; t++) begin
      if (tr_ctrl[t][ROW_BITS+3] === 1'b1) nclk++;
      if (tr_ctrl[t][ROW_BITS+2] === 1'b1) nstb++;
      if (tr_ctrl[t][ROW_BITS+1] === 1'b0) noe++;
      if (t >= 16 && tr_ctrl[t][ROW_BITS+3:ROW_BITS+1] !== 3'b001) viol++;
    end
    checks++;
    if (nclk != COLS || nstb != 1) begin
      errors++;
      $display("FAIL enable_complete: got %0d clocks %0d latches want 4 and 1", nclk, nstb);
    end
    checks++;
    if (noe != 2 || tr_ctrl[14][ROW_BITS+1] !== 1'b0 || tr_ctrl[15][ROW_BITS+1] !== 1'b0) begin
      errors++;
      $display("FAIL enable_oe: got %0d lit cycles (oe_n@14=%b @15=%b) want 2 at 14,15",
               noe, tr_ctrl[14][ROW_BITS+1], tr_ctrl[15][ROW_BITS+1]);
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL enable_hold: got %0d active cycles while disabled want 0", viol);
    end
    top = mem_top[0];
    checks++;
    if (tr_ctrl[43][ROW_BITS+3] !== 1'b1 || tr_data[43][5:3] !== {top[5], top[3], top[1]}) begin
      errors++;
      $display("FAIL enable_resume: got clk=%b m0=%b want clk=1 m0=%b",
               tr_ctrl[43][ROW_BITS+3], tr_data[43][5:3], {top[5], top[3], top[1]});
    end
    $display("test_enable done");
  endtask

  task automatic test_reset_mid();
    int bad, first, st, len;
    randomize_mem();
    release_and_trace(66);
    checks++;
    if (tr_ctrl[65][ROW_BITS+1] !== 1'b0 || tr_ctrl[65][ROW_BITS-1:0] !== ROW_BITS'(1)) begin
      errors++;
      $display("FAIL mid_precond: got oe_n=%b demux=%0d want 0 and 1",
               tr_ctrl[65][ROW_BITS+1], tr_ctrl[65][ROW_BITS-1:0]);
    end
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if (oe_n !== 1'b1 || demux !== '0 || pix_addr !== '0 || matrix_clk !== 1'b0) begin
      errors++;
      $display("FAIL mid_async: got oe_n=%b demux=%0d addr=%0d clk=%b want 1 0 0 0",
               oe_n, demux, pix_addr, matrix_clk);
    end
    repeat (2) @(posedge led_clk);
    @(negedge led_clk);
    rst_i = 1'b0;
    record(0);
    for (int t = 1; t < 40; t++) begin
      @(negedge led_clk);
      record(t);
    end
    build_model(40);
    bad = 0; first = -1;
    for (int t = 0; t < 40; t++)
      if (tr_ctrl[t] !== ex_ctrl[t] || tr_data[t] !== ex_data[t]) begin
        bad++; if (first < 0) first = t;
      end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_restart: %0d bad cycles, first %0d got %b/%b want %b/%b",
               bad, first, tr_ctrl[first], tr_data[first], ex_ctrl[first], ex_data[first]);
    end
    st = -1; len = 0;
    for (int t = 0; t < 40; t++)
      if (tr_ctrl[t][ROW_BITS+1] === 1'b0) begin
        if (st < 0) st = t;
        if (st >= 0 && t == st + len) len++;
      end
    checks++;
    if (tr_addr[1] !== '0 || st != 14 || len != 2) begin
      errors++;
      $display("FAIL mid_first_plane: got addr=%0d lit at %0d for %0d want 0, 14, 2",
               tr_addr[1], st, len);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_datapath();
    test_enable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
